// File: rtl/axi_node_seq_pkg.sv
// Shared constants and helpers for the AXI node write-ordering logic.
package axi_node_seq_pkg;

  localparam int                BEAT_W   = 8;
  localparam logic [BEAT_W-1:0] BEAT_SAT = 8'd255;
  localparam int                MAX_SLV  = 32;

  // One-hot of a slave index; callers cast the result down to their port count.
  function automatic logic [MAX_SLV-1:0] idx_to_onehot(input int unsigned idx);
    return MAX_SLV'(1) << idx;
  endfunction

endpackage

// File: rtl/axi_seq_fifo.sv
// Register-based FIFO with occupancy count and combinational head output.
module axi_seq_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // NOTE: storage is not reset; an entry is only observed once count marks it valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/axi_w_order_sequencer.sv
// Records AW destinations in order and steers W beats to the head destination until w_last.
module axi_w_order_sequencer
  import axi_node_seq_pkg::*;
#(
  parameter  int N_SLAVE    = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int SLV_W      = $clog2(N_SLAVE),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               aw_valid_i,
  input  logic [SLV_W-1:0]   aw_dest_i,
  output logic               aw_ready_o,
  output logic               aw_valid_o,
  input  logic               aw_ready_i,
  input  logic               w_valid_i,
  input  logic               w_last_i,
  output logic               w_ready_o,
  output logic [N_SLAVE-1:0] w_valid_o,
  input  logic [N_SLAVE-1:0] w_ready_i,
  output logic [CNT_W-1:0]   count_o,
  output logic [BEAT_W-1:0]  beat_cnt_o
);

  logic               full;
  logic               empty;
  logic               aw_hs;
  logic               w_hs;
  logic               pop;
  logic [SLV_W-1:0]   head;
  logic [N_SLAVE-1:0] head_oh;
  logic [BEAT_W-1:0]  beat_cnt;

  assign aw_valid_o = aw_valid_i & ~full;
  assign aw_ready_o = aw_ready_i & ~full;
  assign aw_hs      = aw_valid_i & aw_ready_i & ~full;

  // W routing looks only at the registered head, never at this cycle's AW.
  assign head_oh   = N_SLAVE'(idx_to_onehot(32'(head)));
  assign w_valid_o = empty ? '0 : (head_oh & {N_SLAVE{w_valid_i}});
  assign w_ready_o = ~empty & w_ready_i[head];
  assign w_hs      = w_valid_i & w_ready_o;
  assign pop       = w_hs & w_last_i;

  axi_seq_fifo #(
    .WIDTH (SLV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_hs),
    .din   (aw_dest_i),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  always_ff @(posedge clk) begin
    if (rst || pop) begin
      beat_cnt <= '0;
    end else if (w_hs && beat_cnt != BEAT_SAT) begin
      beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  assign beat_cnt_o = beat_cnt;

endmodule

// File: tb/tb_axi_w_order_sequencer.sv
// Randomized and directed bench with an in-order queue model of the write sequencer.
module tb_axi_w_order_sequencer;

  localparam int N = 4;
  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       aw_valid_i;
  logic [1:0] aw_dest_i;
  logic       aw_ready_o;
  logic       aw_valid_o;
  logic       aw_ready_i;
  logic       w_valid_i;
  logic       w_last_i;
  logic       w_ready_o;
  logic [3:0] w_valid_o;
  logic [3:0] w_ready_i;
  logic [2:0] count_o;
  logic [7:0] beat_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of destinations plus current beat count.
  int q[$];
  int m_beat   = 0;
  bit model_on = 0;

  axi_w_order_sequencer #(.N_SLAVE(N), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .aw_valid_i (aw_valid_i),
    .aw_dest_i  (aw_dest_i),
    .aw_ready_o (aw_ready_o),
    .aw_valid_o (aw_valid_o),
    .aw_ready_i (aw_ready_i),
    .w_valid_i  (w_valid_i),
    .w_last_i   (w_last_i),
    .w_ready_o  (w_ready_o),
    .w_valid_o  (w_valid_o),
    .w_ready_i  (w_ready_i),
    .count_o    (count_o),
    .beat_cnt_o (beat_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare on the falling edge, then advance the model to the state after the next rising edge.
  always @(negedge clk) begin
    int         head;
    bit         full;
    bit         aw_hs;
    bit         w_hs;
    logic [3:0] exp_wv;
    logic       exp_wr;
    full   = (q.size() == D);
    exp_wv = '0;
    exp_wr = 1'b0;
    if (q.size() != 0) begin
      head         = q[0];
      exp_wv[head] = w_valid_i;
      exp_wr       = w_ready_i[head];
    end
    if (model_on) begin
      check("aw_valid_o", 32'(aw_valid_o), 32'(aw_valid_i && !full));
      check("aw_ready_o", 32'(aw_ready_o), 32'(aw_ready_i && !full));
      check("w_valid_o", 32'(w_valid_o), 32'(exp_wv));
      check("w_ready_o", 32'(w_ready_o), 32'(exp_wr));
      check("count_o", 32'(count_o), 32'(q.size()));
      check("beat_cnt_o", 32'(beat_cnt_o), 32'(m_beat));
      check("count_bound", 32'(count_o <= 3'd4), 32'(1));
    end
    if (rst) begin
      q.delete();
      m_beat   = 0;
      model_on = 1;
    end else if (model_on) begin
      aw_hs = aw_valid_i && aw_ready_i && !full;
      w_hs  = w_valid_i && exp_wr;
      if (w_hs && w_last_i) begin
        void'(q.pop_front());
        m_beat = 0;
      end else if (w_hs && m_beat < 255) begin
        m_beat++;
      end
      if (aw_hs) q.push_back(int'(aw_dest_i));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aw_valid_i = 1'b0;
    aw_dest_i  = 2'd0;
    aw_ready_i = 1'b1;
    w_valid_i  = 1'b0;
    w_last_i   = 1'b0;
    w_ready_i  = 4'hF;
  endtask

  task automatic push_aw(input logic [1:0] d);
    aw_valid_i = 1'b1;
    aw_dest_i  = d;
    step();
    aw_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) step();
    rst = 1'b0;

    // Empty queue stalls W.
    w_valid_i = 1'b1;
    repeat (3) begin
      #1;
      check("idle_w_valid", 32'(w_valid_o), 32'h0);
      check("idle_w_ready", 32'(w_ready_o), 32'h0);
      check("idle_count", 32'(count_o), 32'h0);
      step();
    end

    // One 4-beat burst to slave 2.
    w_valid_i = 1'b0;
    push_aw(2'd2);
    w_valid_i = 1'b1;
    #1;
    check("burst_count", 32'(count_o), 32'h1);
    for (int b = 0; b < 4; b++) begin
      w_last_i = (b == 3);
      #1;
      check("burst_route", 32'(w_valid_o), 32'h4);
      check("burst_beat", 32'(beat_cnt_o), 32'(b));
      step();
    end
    idle();
    #1;
    check("burst_done_count", 32'(count_o), 32'h0);
    check("burst_done_beat", 32'(beat_cnt_o), 32'h0);

    // Fill, hold a fifth AW, then drain single-beat bursts in order.
    for (int d = 0; d < 4; d++) begin
      aw_valid_i = 1'b1;
      aw_dest_i  = 2'(d);
      step();
    end
    aw_dest_i = 2'd0;
    repeat (2) begin
      #1;
      check("fill_count", 32'(count_o), 32'h4);
      check("fill_aw_ready", 32'(aw_ready_o), 32'h0);
      check("fill_aw_valid", 32'(aw_valid_o), 32'h0);
      step();
    end
    aw_valid_i = 1'b0;
    w_valid_i  = 1'b1;
    w_last_i   = 1'b1;
    for (int d = 0; d < 4; d++) begin
      #1;
      check("drain_order", 32'(w_valid_o), 32'(1) << d);
      step();
    end
    idle();

    // Push and pop on the same edge.
    push_aw(2'd3);
    push_aw(2'd0);
    aw_valid_i = 1'b1;
    aw_dest_i  = 2'd1;
    w_valid_i  = 1'b1;
    w_last_i   = 1'b1;
    #1;
    check("pp_before_count", 32'(count_o), 32'h2);
    check("pp_before_route", 32'(w_valid_o), 32'h8);
    step();
    aw_valid_i = 1'b0;
    #1;
    check("pp_count", 32'(count_o), 32'h2);
    check("pp_route0", 32'(w_valid_o), 32'h1);
    step();
    #1;
    check("pp_route1", 32'(w_valid_o), 32'h2);
    step();
    idle();

    // Beat counter saturation.
    push_aw(2'd1);
    w_valid_i = 1'b1;
    repeat (260) step();
    #1;
    check("beat_sat", 32'(beat_cnt_o), 32'd255);
    w_last_i = 1'b1;
    step();
    idle();
    #1;
    check("beat_sat_clear", 32'(beat_cnt_o), 32'h0);

    // Random traffic with AW/W stalls; the model checks every cycle.
    repeat (800) begin
      aw_valid_i = ($urandom_range(0, 1) != 0);
      aw_dest_i  = 2'($urandom_range(0, 3));
      aw_ready_i = ($urandom_range(0, 3) != 0);
      w_valid_i  = ($urandom_range(0, 3) != 0);
      w_last_i   = ($urandom_range(0, 2) == 0);
      w_ready_i  = 4'($urandom_range(0, 15));
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Reset in the middle of a burst.
    push_aw(2'd1);
    push_aw(2'd2);
    push_aw(2'd0);
    w_valid_i = 1'b1;
    w_last_i  = 1'b0;
    repeat (5) step();
    #1;
    check("mid_count", 32'(count_o), 32'h3);
    check("mid_beat", 32'(beat_cnt_o), 32'h5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_beat", 32'(beat_cnt_o), 32'h0);
    check("rst_w_valid", 32'(w_valid_o), 32'h0);
    w_valid_i = 1'b0;
    push_aw(2'd3);
    w_valid_i = 1'b1;
    w_last_i  = 1'b1;
    #1;
    check("post_rst_route", 32'(w_valid_o), 32'h8);
    step();
    idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
